// File: rtl/eth_hdr_strip_filter.sv
// Ethernet header filter/stripper: drops frames with the wrong dst MAC/EtherType, forwards payload realigned to byte 0.
// Latency: first payload beat is valid the cycle after the third input beat is accepted; FLUSH adds one cycle when the tail spills over.
// Backpressure: header/drop beats always accepted; payload beats stall on a full output slot; FLUSH holds input ready low.
module eth_hdr_strip_filter #(
    parameter logic [47:0] MAC_ADDR     = 48'h000A35000001,
    parameter logic [15:0] ETHERTYPE    = 16'h7400,
    parameter bit          ACCEPT_BCAST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] stream_in_DATA,
    input  logic [7:0]  stream_in_KEEP,
    input  logic        stream_in_LAST,
    input  logic        stream_in_VALID,
    output logic        stream_in_READY,
    output logic [63:0] stream_out_DATA,
    output logic [7:0]  stream_out_KEEP,
    output logic        stream_out_LAST,
    output logic        stream_out_VALID,
    input  logic        stream_out_READY,
    output logic [31:0] frames_passed,
    output logic [31:0] frames_dropped
);

    typedef enum logic [2:0] {HDR0, HDR1, PAYLOAD, FLUSH, DROP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        mac_ok;
    logic [15:0] prev_data;
    logic [1:0]  prev_keep;

    logic        slot_free;
    logic        accept;
    logic [47:0] dst_mac;
    logic [15:0] ether_type;
    logic        latch_mac;
    logic        load_hdr_tail;
    logic        load_pay;
    logic        load_flush;
    logic        inc_pass;
    logic        inc_drop;

    // Wire byte 0 is the MSB of the MAC address, so reverse the byte order.
    assign dst_mac    = {stream_in_DATA[7:0],   stream_in_DATA[15:8],  stream_in_DATA[23:16],
                         stream_in_DATA[31:24], stream_in_DATA[39:32], stream_in_DATA[47:40]};
    assign ether_type = {stream_in_DATA[39:32], stream_in_DATA[47:40]};
    assign slot_free  = !stream_out_VALID || stream_out_READY;
    assign accept     = stream_in_VALID && stream_in_READY;

    always_comb begin
        stream_in_READY = 1'b0;
        case (state)
            HDR0, HDR1, DROP: stream_in_READY = 1'b1;
            PAYLOAD:          stream_in_READY = slot_free;
            default:          stream_in_READY = 1'b0;
        endcase
        if (reset) begin
            stream_in_READY = 1'b0;
        end
    end

    always_comb begin
        state_nxt     = state;
        latch_mac     = 1'b0;
        load_hdr_tail = 1'b0;
        load_pay      = 1'b0;
        load_flush    = 1'b0;
        inc_pass      = 1'b0;
        inc_drop      = 1'b0;
        case (state)
            HDR0: begin
                if (accept) begin
                    if (stream_in_LAST) begin
                        inc_drop = 1'b1;
                    end else begin
                        latch_mac = 1'b1;
                        state_nxt = HDR1;
                    end
                end
            end
            HDR1: begin
                if (accept) begin
                    if (stream_in_LAST) begin
                        inc_drop  = 1'b1;
                        state_nxt = HDR0;
                    end else if (mac_ok && (ether_type == ETHERTYPE)) begin
                        load_hdr_tail = 1'b1;
                        state_nxt     = PAYLOAD;
                    end else begin
                        state_nxt = DROP;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    load_pay = 1'b1;
                    if (stream_in_LAST) begin
                        if (stream_in_KEEP[7:6] == 2'b00) begin
                            inc_pass  = 1'b1;
                            state_nxt = HDR0;
                        end else begin
                            state_nxt = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    load_flush = 1'b1;
                    inc_pass   = 1'b1;
                    state_nxt  = HDR0;
                end
            end
            DROP: begin
                if (accept && stream_in_LAST) begin
                    inc_drop  = 1'b1;
                    state_nxt = HDR0;
                end
            end
            default: state_nxt = HDR0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= HDR0;
            mac_ok           <= 1'b0;
            prev_data        <= 16'h0;
            prev_keep        <= 2'b00;
            stream_out_DATA  <= 64'h0;
            stream_out_KEEP  <= 8'h0;
            stream_out_LAST  <= 1'b0;
            stream_out_VALID <= 1'b0;
            frames_passed    <= 32'h0;
            frames_dropped   <= 32'h0;
        end else begin
            state <= state_nxt;
            if (latch_mac) begin
                mac_ok <= (dst_mac == MAC_ADDR) || (ACCEPT_BCAST && (dst_mac == 48'hFFFF_FFFF_FFFF));
            end
            if (load_hdr_tail) begin
                prev_data <= stream_in_DATA[63:48];
                prev_keep <= 2'b11;
            end
            // Each payload beat carries the two bytes held back from the previous beat in its low lanes.
            if (load_pay) begin
                stream_out_DATA  <= {stream_in_DATA[47:0], prev_data};
                stream_out_KEEP  <= {stream_in_KEEP[5:0], prev_keep};
                stream_out_LAST  <= stream_in_LAST && (stream_in_KEEP[7:6] == 2'b00);
                stream_out_VALID <= 1'b1;
                prev_data        <= stream_in_DATA[63:48];
                prev_keep        <= stream_in_KEEP[7:6];
            end else if (load_flush) begin
                stream_out_DATA  <= {48'h0, prev_data};
                stream_out_KEEP  <= {6'h0, prev_keep};
                stream_out_LAST  <= 1'b1;
                stream_out_VALID <= 1'b1;
            end else if (stream_out_VALID && stream_out_READY) begin
                stream_out_VALID <= 1'b0;
            end
            if (inc_pass) begin
                frames_passed <= frames_passed + 32'd1;
            end
            if (inc_drop) begin
                frames_dropped <= frames_dropped + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_eth_hdr_strip_filter.sv
// Directed bench for eth_hdr_strip_filter: pass/drop/runt/flush/stall/reset scenarios.
module tb_eth_hdr_strip_filter;

    localparam logic [47:0] MAC = 48'h000A35000001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] stream_in_DATA = '0;
    logic [7:0]  stream_in_KEEP = '0;
    logic        stream_in_LAST = 1'b0;
    logic        stream_in_VALID = 1'b0;
    logic        stream_in_READY;
    logic [63:0] stream_out_DATA;
    logic [7:0]  stream_out_KEEP;
    logic        stream_out_LAST;
    logic        stream_out_VALID;
    logic        stream_out_READY = 1'b1;
    logic [31:0] frames_passed;
    logic [31:0] frames_dropped;

    eth_hdr_strip_filter dut (
        .clk(clk), .reset(reset),
        .stream_in_DATA(stream_in_DATA), .stream_in_KEEP(stream_in_KEEP),
        .stream_in_LAST(stream_in_LAST), .stream_in_VALID(stream_in_VALID),
        .stream_in_READY(stream_in_READY),
        .stream_out_DATA(stream_out_DATA), .stream_out_KEEP(stream_out_KEEP),
        .stream_out_LAST(stream_out_LAST), .stream_out_VALID(stream_out_VALID),
        .stream_out_READY(stream_out_READY),
        .frames_passed(frames_passed), .frames_dropped(frames_dropped)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int exp_pass = 0;
    int exp_drop = 0;
    bit rand_stall = 1'b0;

    logic [7:0] frame[$];
    logic [7:0] exp_bytes[$];
    int         exp_lens[$];
    logic [7:0] out_bytes[$];
    logic [7:0] out_keeps[$];
    logic       out_lasts[$];
    int         out_lens[$];
    int         cur_len = 0;

    logic [63:0] held_data;
    logic [7:0]  held_keep;
    logic        held_last;
    bit          held = 1'b0;

    always @(posedge clk) begin
        #1;
        stream_out_READY = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: records transfers and checks that a stalled beat does not change.
    always @(negedge clk) begin
        if (reset) begin
            held = 1'b0;
            cur_len = 0;
        end else begin
            if (held) begin
                checks++;
                if (stream_out_VALID !== 1'b1 || stream_out_DATA !== held_data ||
                    stream_out_KEEP !== held_keep || stream_out_LAST !== held_last) begin
                    failures++;
                    $display("FAIL stall_stable got v=%b d=%h k=%h l=%b want v=1 d=%h k=%h l=%b",
                             stream_out_VALID, stream_out_DATA, stream_out_KEEP, stream_out_LAST,
                             held_data, held_keep, held_last);
                end
            end
            if (stream_out_VALID && stream_out_READY) begin
                out_keeps.push_back(stream_out_KEEP);
                out_lasts.push_back(stream_out_LAST);
                for (int i = 0; i < 8; i++) begin
                    if (stream_out_KEEP[i]) begin
                        out_bytes.push_back(stream_out_DATA[8*i +: 8]);
                        cur_len++;
                    end
                end
                if (stream_out_LAST) begin
                    out_lens.push_back(cur_len);
                    cur_len = 0;
                end
            end
            held      = stream_out_VALID && !stream_out_READY;
            held_data = stream_out_DATA;
            held_keep = stream_out_KEEP;
            held_last = stream_out_LAST;
        end
    end

    task automatic build_frame(input logic [47:0] dst, input logic [15:0] et, input int len,
                               input int seed, input bit expect_pass);
        frame.delete();
        for (int i = 0; i < 6; i++) frame.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frame.push_back(8'(8'h02 + 8'h11 * i));
        frame.push_back(et[15:8]);
        frame.push_back(et[7:0]);
        for (int k = 0; k < len - 14; k++) frame.push_back(8'(seed + k));
        if (expect_pass) begin
            for (int k = 0; k < len - 14; k++) exp_bytes.push_back(8'(seed + k));
            exp_lens.push_back(len - 14);
        end
    endtask

    task automatic clear_queues();
        exp_bytes.delete(); exp_lens.delete();
        out_bytes.delete(); out_keeps.delete(); out_lasts.delete(); out_lens.delete();
    endtask

    // Drives the current frame (up to max_beats beats); returns #1 after the last accepting edge.
    task automatic send_frame(input int max_beats, output int stalls);
        int n;
        int nb;
        bit acc;
        int t;
        n = frame.size();
        nb = (n + 7) / 8;
        if (max_beats < nb) nb = max_beats;
        stalls = 0;
        for (int b = 0; b < nb; b++) begin
            stream_in_DATA = '0;
            stream_in_KEEP = '0;
            for (int i = 0; i < 8; i++) begin
                if (b*8 + i < n) begin
                    stream_in_DATA[8*i +: 8] = frame[b*8 + i];
                    stream_in_KEEP[i] = 1'b1;
                end
            end
            stream_in_LAST  = (b*8 + 8 >= n);
            stream_in_VALID = 1'b1;
            acc = 1'b0;
            t = 0;
            while (!acc) begin
                @(negedge clk);
                acc = stream_in_READY;
                if (!acc) stalls++;
                @(posedge clk);
                #1;
                t++;
                if (!acc && t > 500) begin
                    checks++;
                    failures++;
                    $display("FAIL input_accept_timeout beat=%0d got no ready want ready", b);
                    stream_in_VALID = 1'b0;
                    return;
                end
            end
        end
        stream_in_VALID = 1'b0;
        stream_in_LAST  = 1'b0;
    endtask

    task automatic drain();
        int quiet;
        quiet = 0;
        for (int t = 0; t < 400 && quiet < 3; t++) begin
            @(negedge clk);
            quiet = stream_out_VALID ? 0 : quiet + 1;
        end
        if (quiet < 3) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got valid still active want idle");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stream_in_READY !== 1'b0 || stream_out_VALID !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_valid got rdy=%b vld=%b want 0 0", stream_in_READY, stream_out_VALID);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (frames_passed !== 32'd0 || frames_dropped !== 32'd0 || stream_out_DATA !== 64'h0 ||
            stream_out_KEEP !== 8'h0 || stream_out_LAST !== 1'b0 || stream_in_READY !== 1'b1) begin
            failures++;
            $display("FAIL reset_state got p=%0d d=%0d dat=%h k=%h l=%b rdy=%b want 0 0 0 0 0 1",
                     frames_passed, frames_dropped, stream_out_DATA, stream_out_KEEP,
                     stream_out_LAST, stream_in_READY);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_pass_64();
        int st;
        int errs;
        clear_queues();
        build_frame(MAC, 16'h7400, 64, 0, 1'b1);
        send_frame(100, st);
        drain();
        exp_pass++;
        checks++;
        if (out_keeps.size() != 7) begin
            failures++;
            $display("FAIL pass64_beats got %0d want 7", out_keeps.size());
        end else begin
            checks++;
            if (out_keeps[6] !== 8'h03 || out_lasts[6] !== 1'b1 || out_lasts[5] !== 1'b0 || out_keeps[0] !== 8'hFF) begin
                failures++;
                $display("FAIL pass64_tail got k0=%h k6=%h l5=%b l6=%b want ff 03 0 1",
                         out_keeps[0], out_keeps[6], out_lasts[5], out_lasts[6]);
            end
        end
        errs = 0;
        for (int k = 0; k < 50; k++) if (k >= out_bytes.size() || out_bytes[k] !== 8'(k)) errs++;
        checks++;
        if (out_bytes.size() != 50 || errs != 0) begin
            failures++;
            $display("FAIL pass64_bytes got %0d bytes (%0d bad) want 50 bytes 00..31", out_bytes.size(), errs);
        end
        checks++;
        if (frames_passed !== 32'd1) begin
            failures++;
            $display("FAIL pass64_count got %0d want 1", frames_passed);
        end
    endtask

    task automatic test_drop_mac();
        int st;
        clear_queues();
        build_frame(48'h020000000009, 16'h7400, 64, 0, 1'b0);
        send_frame(100, st);
        drain();
        exp_drop++;
        checks++;
        if (st != 0 || out_keeps.size() != 0) begin
            failures++;
            $display("FAIL drop_mac_output got stalls=%0d beats=%0d want 0 0", st, out_keeps.size());
        end
        checks++;
        if (frames_dropped !== 32'(exp_drop) || frames_passed !== 32'(exp_pass)) begin
            failures++;
            $display("FAIL drop_mac_count got d=%0d p=%0d want %0d %0d", frames_dropped, frames_passed, exp_drop, exp_pass);
        end
    endtask

    task automatic test_bcast_etype();
        int st;
        int errs;
        clear_queues();
        build_frame(48'hFFFF_FFFF_FFFF, 16'h7400, 30, 8'h40, 1'b1);
        send_frame(100, st);
        build_frame(MAC, 16'h0800, 40, 8'h60, 1'b0);
        send_frame(100, st);
        drain();
        exp_pass++;
        exp_drop++;
        errs = 0;
        for (int k = 0; k < 16; k++) if (k >= out_bytes.size() || out_bytes[k] !== 8'(8'h40 + k)) errs++;
        checks++;
        if (out_bytes.size() != 16 || errs != 0) begin
            failures++;
            $display("FAIL bcast_bytes got %0d bytes (%0d bad) want 16 bytes 40..4f", out_bytes.size(), errs);
        end
        checks++;
        if (frames_passed !== 32'(exp_pass) || frames_dropped !== 32'(exp_drop)) begin
            failures++;
            $display("FAIL bcast_etype_count got p=%0d d=%0d want %0d %0d", frames_passed, frames_dropped, exp_pass, exp_drop);
        end
    endtask

    task automatic test_short20();
        int st;
        clear_queues();
        build_frame(MAC, 16'h7400, 20, 8'hA0, 1'b1);
        send_frame(100, st);
        drain();
        exp_pass++;
        checks++;
        if (out_keeps.size() != 1) begin
            failures++;
            $display("FAIL short20_beats got %0d want 1", out_keeps.size());
        end else begin
            checks++;
            if (out_keeps[0] !== 8'h3F || out_lasts[0] !== 1'b1 || out_bytes[0] !== 8'hA0 || out_bytes[5] !== 8'hA5) begin
                failures++;
                $display("FAIL short20_beat got k=%h l=%b b0=%h b5=%h want 3f 1 a0 a5",
                         out_keeps[0], out_lasts[0], out_bytes[0], out_bytes[5]);
            end
        end
    endtask

    task automatic test_flush24();
        int st;
        clear_queues();
        build_frame(MAC, 16'h7400, 24, 8'hC0, 1'b1);
        send_frame(100, st);
        @(negedge clk);
        checks++;
        if (stream_in_READY !== 1'b0 || stream_out_KEEP !== 8'hFF || stream_out_LAST !== 1'b0) begin
            failures++;
            $display("FAIL flush_cycle got rdy=%b k=%h l=%b want 0 ff 0", stream_in_READY, stream_out_KEEP, stream_out_LAST);
        end
        @(negedge clk);
        checks++;
        if (stream_in_READY !== 1'b1 || stream_out_VALID !== 1'b1 || stream_out_KEEP !== 8'h03 ||
            stream_out_LAST !== 1'b1 || stream_out_DATA !== 64'h0000_0000_0000_C9C8) begin
            failures++;
            $display("FAIL flush_beat got rdy=%b v=%b k=%h l=%b d=%h want 1 1 03 1 000000000000c9c8",
                     stream_in_READY, stream_out_VALID, stream_out_KEEP, stream_out_LAST, stream_out_DATA);
        end
        drain();
        exp_pass++;
        checks++;
        if (out_keeps.size() != 2 || out_lens.size() != 1 || out_bytes.size() != 10) begin
            failures++;
            $display("FAIL flush24_shape got beats=%0d frames=%0d bytes=%0d want 2 1 10",
                     out_keeps.size(), out_lens.size(), out_bytes.size());
        end
    endtask

    task automatic test_runt();
        int st;
        clear_queues();
        build_frame(MAC, 16'h7400, 8, 0, 1'b0);
        frame = frame[0:7];
        send_frame(100, st);
        build_frame(MAC, 16'h7400, 16, 8'h10, 1'b0);
        send_frame(100, st);
        drain();
        exp_drop += 2;
        checks++;
        if (frames_dropped !== 32'(exp_drop) || frames_passed !== 32'(exp_pass) || out_keeps.size() != 0) begin
            failures++;
            $display("FAIL runt_count got d=%0d p=%0d beats=%0d want %0d %0d 0",
                     frames_dropped, frames_passed, out_keeps.size(), exp_drop, exp_pass);
        end
    endtask

    task automatic test_back_to_back_stall();
        int st;
        int errs;
        int len;
        clear_queues();
        rand_stall = 1'b1;
        for (int f = 0; f < 20; f++) begin
            len = $urandom_range(17, 90);
            build_frame(MAC, 16'h7400, len, f * 13, 1'b1);
            send_frame(100, st);
        end
        drain();
        rand_stall = 1'b0;
        exp_pass += 20;
        errs = 0;
        for (int k = 0; k < exp_bytes.size(); k++) if (k >= out_bytes.size() || out_bytes[k] !== exp_bytes[k]) errs++;
        checks++;
        if (out_bytes.size() != exp_bytes.size() || errs != 0) begin
            failures++;
            $display("FAIL stall_bytes got %0d bytes (%0d bad) want %0d", out_bytes.size(), errs, exp_bytes.size());
        end
        errs = 0;
        for (int f = 0; f < exp_lens.size(); f++) if (f >= out_lens.size() || out_lens[f] != exp_lens[f]) errs++;
        checks++;
        if (out_lens.size() != exp_lens.size() || errs != 0) begin
            failures++;
            $display("FAIL stall_frame_lens got %0d frames (%0d bad) want %0d", out_lens.size(), errs, exp_lens.size());
        end
        checks++;
        if (frames_passed !== 32'(exp_pass)) begin
            failures++;
            $display("FAIL stall_count got %0d want %0d", frames_passed, exp_pass);
        end
    endtask

    task automatic test_reset_mid();
        int st;
        int errs;
        clear_queues();
        build_frame(MAC, 16'h7400, 64, 8'h80, 1'b0);
        send_frame(3, st);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (stream_out_VALID !== 1'b0 || stream_in_READY !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got v=%b rdy=%b want 0 0", stream_out_VALID, stream_in_READY);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_pass = 0;
        exp_drop = 0;
        clear_queues();
        build_frame(MAC, 16'h7400, 40, 8'h90, 1'b1);
        send_frame(100, st);
        drain();
        exp_pass++;
        errs = 0;
        for (int k = 0; k < 26; k++) if (k >= out_bytes.size() || out_bytes[k] !== 8'(8'h90 + k)) errs++;
        checks++;
        if (out_bytes.size() != 26 || errs != 0 || frames_passed !== 32'd1 || frames_dropped !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_next got %0d bytes (%0d bad) p=%0d d=%0d want 26 bytes 90.. p=1 d=0",
                     out_bytes.size(), errs, frames_passed, frames_dropped);
        end
    endtask

    initial begin
        test_reset();
        test_pass_64();
        test_drop_mac();
        test_bcast_etype();
        test_short20();
        test_flush24();
        test_runt();
        test_back_to_back_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
